// File: rtl/tap_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tap_serializer
// Purpose  : Parallel-in, serial-out shifter. Streams a DEPTH-element word
//            top element first, so a tapped_fifo rebuilds it on its taps.
// Revision : 1.0 - initial release
// ============================================================================
module tap_serializer #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 10,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [WIDTH*DEPTH-1:0] load_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_last,
   output logic [CW-1:0]          count
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                   state;
   state_t                   state_next;
   logic [WIDTH*DEPTH-1:0]   shreg;
   logic                     on_last;
   logic                     load_fire;
   logic                     beat;

   assign on_last    = (state == STREAM) && (count == CW'(1));
   assign load_ready = (state == IDLE) || (on_last && out_ready);
   assign load_fire  = load_valid && load_ready;
   assign beat       = (state == STREAM) && out_ready;

   assign out_valid  = (state == STREAM);
   assign out_data   = shreg[(DEPTH-1)*WIDTH +: WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_valid) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (on_last && out_ready && !load_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A load on the final beat reloads in place, so words run with no bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg    <= '0;
         count    <= '0;
         out_last <= 1'b0;
      end else if (load_fire) begin
         shreg    <= load_data;
         count    <= CW'(DEPTH);
         out_last <= (DEPTH == 1);
      end else if (beat) begin
         if (int'(count) > 1) begin
            shreg    <= shreg << WIDTH;
            count    <= count - CW'(1);
            out_last <= (int'(count) == 2);
         end else begin
            shreg    <= '0;
            count    <= '0;
            out_last <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tap_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_serializer
// Purpose  : Scoreboarded random and directed bench for tap_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tap_serializer;

   localparam int AW  = 1;
   localparam int AD  = 10;
   localparam int ACW = $clog2(AD + 1);
   localparam int BW  = 4;
   localparam int BD  = 1;
   localparam int BCW = $clog2(BD + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b0;

   logic              a_load_valid = 1'b0;
   logic              a_load_ready;
   logic [AW*AD-1:0]  a_load_data = '0;
   logic              a_out_valid;
   logic              a_out_ready = 1'b0;
   logic [AW-1:0]     a_out_data;
   logic              a_out_last;
   logic [ACW-1:0]    a_count;

   logic              b_load_valid = 1'b0;
   logic              b_load_ready;
   logic [BW*BD-1:0]  b_load_data = '0;
   logic              b_out_valid;
   logic              b_out_ready = 1'b0;
   logic [BW-1:0]     b_out_data;
   logic              b_out_last;
   logic [BCW-1:0]    b_count;

   tap_serializer #(.WIDTH(AW), .DEPTH(AD)) dut_a (
      .clk(clk), .rst(rst),
      .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .count(a_count)
   );

   tap_serializer #(.WIDTH(BW), .DEPTH(BD)) dut_b (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .count(b_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] data;
      logic          last;
      int            cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   rand_mode = 1'b0;
   bit   bb_watch = 1'b0;
   int   bb_drops = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a word expands to its elements, top index first, with the
   // remaining-element count and the last flag attached to each beat.
   always @(negedge clk) begin
      if (rst && a_load_valid && a_load_ready) begin
         for (int k = AD - 1; k >= 0; k--) begin
            exp_t e;
            e.data = a_load_data[k*AW +: AW];
            e.last = (k == 0);
            e.cnt  = k + 1;
            exp_q.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (a_out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'd1, 32'd0);
            end else begin
               check("out_data", 32'(a_out_data), 32'(exp_q[0].data));
               check("out_last", 32'(a_out_last), 32'(exp_q[0].last));
               check("count",    32'(a_count),    32'(exp_q[0].cnt));
               if (a_out_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("idle_count", 32'(a_count), 32'd0);
         end
         if (bb_watch && !a_out_valid) bb_drops++;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rand_mode) a_out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send_word(input logic [AW*AD-1:0] w, output int waited);
      bit acc;
      a_load_valid = 1'b1;
      a_load_data  = w;
      waited = 0;
      do begin
         @(negedge clk);
         acc = a_load_ready;
         @(posedge clk);
         #1;
         waited++;
      end while (!acc && waited < 200);
      a_load_valid = 1'b0;
      if (!acc) check("load_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || a_out_valid) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) check("drain_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [AW*AD-1:0] word;
      word = 10'b1011001110;

      repeat (2) @(posedge clk);
      #1;
      check("rst_load_ready", 32'(a_load_ready), 32'd1);
      check("rst_out_valid",  32'(a_out_valid),  32'd0);
      check("rst_count",      32'(a_count),      32'd0);
      check("rst_out_data",   32'(a_out_data),   32'd0);
      check("rst_out_last",   32'(a_out_last),   32'd0);
      rst = 1'b1;

      // Basic stream with latency check on the first beat.
      a_out_ready = 1'b1;
      send_word(word, w);
      @(negedge clk);
      check("first_beat_valid", 32'(a_out_valid), 32'd1);
      check("first_beat_data",  32'(a_out_data),  32'd1);
      @(posedge clk);
      #1;
      drain();
      check("post_load_ready", 32'(a_load_ready), 32'd1);
      check("post_count",      32'(a_count),      32'd0);

      // Backpressure after beat 4.
      send_word(word, w);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      a_out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_data",  32'(a_out_data), 32'd0);
         check("bp_count", 32'(a_count),    32'd6);
         check("bp_last",  32'(a_out_last), 32'd0);
         @(posedge clk);
         #1;
      end
      a_out_ready = 1'b1;
      drain();

      // Back-to-back words.
      send_word(10'h2A5, w);
      bb_watch = 1'b1;
      send_word(10'h15A, w);
      check("b2b_ready_wait", 32'(w), 32'(AD));
      bb_watch = 1'b0;
      check("b2b_valid_drops", 32'(bb_drops), 32'd0);
      drain();

      // Asynchronous reset in the middle of a word.
      send_word(10'h3C7, w);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("arst_out_valid",  32'(a_out_valid),  32'd0);
      check("arst_count",      32'(a_count),      32'd0);
      check("arst_load_ready", 32'(a_load_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      send_word(10'h201, w);
      @(negedge clk);
      check("arst_restart_data", 32'(a_out_data), 32'd1);
      @(posedge clk);
      #1;
      drain();

      // Single-element words, back-to-back.
      b_out_ready  = 1'b1;
      b_load_valid = 1'b1;
      b_load_data  = 4'hA;
      @(negedge clk);
      check("d1_idle_ready", 32'(b_load_ready), 32'd1);
      @(posedge clk);
      #1;
      b_load_data = 4'h5;
      @(negedge clk);
      check("d1_a_valid", 32'(b_out_valid),  32'd1);
      check("d1_a_data",  32'(b_out_data),   32'hA);
      check("d1_a_last",  32'(b_out_last),   32'd1);
      check("d1_a_count", 32'(b_count),      32'd1);
      check("d1_a_ready", 32'(b_load_ready), 32'd1);
      @(posedge clk);
      #1;
      b_load_valid = 1'b0;
      @(negedge clk);
      check("d1_b_valid", 32'(b_out_valid), 32'd1);
      check("d1_b_data",  32'(b_out_data),  32'h5);
      check("d1_b_last",  32'(b_out_last),  32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("d1_end_valid", 32'(b_out_valid), 32'd0);
      check("d1_end_count", 32'(b_count),     32'd0);

      // Random words, gaps and backpressure.
      @(posedge clk);
      #1;
      rand_mode = 1'b1;
      repeat (40) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         send_word(AD'($urandom), w);
      end
      rand_mode = 1'b0;
      @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      drain();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tap_serializer.md
Name: tap_serializer

Overview:
- Parallel-in, serial-out counterpart to the tapped_fifo shift-in/tap-out structure.
- Accepts one DEPTH-element word per handshake and streams its elements out one per beat.
- The output stream is ordered so that shifting it into a tapped_fifo of equal WIDTH/DEPTH reproduces the loaded word on its taps.
- Used to replay census window rows and disparity vectors into serial pipelines.

Parameters:
- WIDTH, 1: bits per element.
- DEPTH, 10: elements per loaded word; legal range is 1 or more.
- CW (localparam), $clog2(DEPTH+1): width of the count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. 0 resets the block.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block accepts a word this cycle.
- load_data  input  WIDTH*DEPTH  element k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  current element.
- out_last  output  1  current element is element 0, the final beat of the word.
- count  output  CW  elements remaining, including the current element. 0 when idle.

Behaviour:
- Transfer conditions:
  - Load transfer = load_valid && load_ready.
  - Beat = out_valid && out_ready.
- Reset (rst=0) takes effect immediately, including mid-stream:
  - state=IDLE.
  - load_ready=1, out_valid=0, out_last=0, count=0.
  - out_data=0 and the shift register is cleared.
  - The partially sent word is discarded.
- FSM state IDLE:
  - load_ready=1, out_valid=0.
  - On a load transfer: capture load_data into the shift register, set count=DEPTH, go to STREAM.
- FSM state STREAM:
  - out_valid=1.
  - out_data = shift register element currently at the top. The first beat is element DEPTH-1; the last beat is element 0.
  - On a beat with count>1: shift by one element toward the top, count decrements.
  - On a beat with count==1: the word is complete.
    - If a load transfer occurs in the same cycle, capture the new word, set count=DEPTH, stay in STREAM. There are no bubbles between words.
    - Otherwise go to IDLE with count=0.
- load_ready is combinational: (state==IDLE) || (state==STREAM && count==1 && out_ready). This is the only combinational input-to-output path.
- out_last = (state==STREAM && count==1).
- Backpressure: while out_valid && !out_ready, out_data, out_last and count hold exactly.
- Latency: the first element appears on out_valid in the cycle after its load transfer. A word takes DEPTH beats when out_ready is held at 1.
- DEPTH=1: every word is a single beat with out_last=1 on that beat.
- All outputs other than load_ready come from registers.

Test Plan:
- Basic stream: DEPTH=10, WIDTH=1, load 10'b1011001110, out_ready=1 -> out_data sequence 1,0,1,1,0,0,1,1,1,0 on 10 consecutive cycles starting 1 cycle after the load; count runs 10..1; out_last only on the 10th beat; then load_ready=1 and count=0.
- Backpressure: same word, out_ready low for 3 cycles after beat 4 -> out_data=0, count=6 and out_last=0 held for those 3 cycles; the sequence then resumes unchanged for 10 beats total.
- Back-to-back: load_valid held high with words A then B -> the first beat of B directly follows the last beat of A with out_valid never dropping; load_ready pulses high only on A's last beat.
- Reset mid-stream: assert rst=0 asynchronously after beat 5 -> out_valid=0, count=0 and load_ready=1 without waiting for a clock edge; after release a new word streams from its element DEPTH-1.
- Round trip: WIDTH=8, DEPTH=3, load {8'hC3,8'h5A,8'h01}, feed beats into tapped_fifo(8,3) -> out_data sequence C3,5A,01; after 3 beats the tapped_fifo taps equal the loaded word.
- Edge case: DEPTH=1, WIDTH=4, load 4'hA then 4'h5 back-to-back -> out_data A then 5 on consecutive cycles, out_last=1 on both beats.
